hyperram_cmd_ctrl: RTL and testbench

Serial-command front end for the HyperRAM burst controller (hbc).
- Parses byte frames from the UART receiver and stages write payload in a word buffer.
- Issues one read or write burst to hbc per frame.
- Returns read words to the UART transmitter as bytes, high byte first.
- All logic runs in the single clk domain; the UART and hbc interfaces are synchronous to clk.

---
 rtl/hyperram_cmd_ctrl.sv | 118 +++++++++++
 tb/tb_hyperram_cmd_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_cmd_ctrl.sv
// hyperram_cmd_ctrl: parses UART byte frames (clk, rst, in_data/in_data_ready), issues one hbc burst per frame (start, rdwr, addr, burst_len, wr_data/next_wr, mdata/mdata_ready, mbusy) and returns read words as bytes (send_byte, send_imp, serial_busy)
module hyperram_cmd_ctrl #(
  parameter int BUF_WORDS = 16,
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_data_ready,
  output logic              start,
  output logic              rdwr,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        burst_len,
  output logic [15:0]       wr_data,
  input  logic              next_wr,
  input  logic [15:0]       mdata,
  input  logic              mdata_ready,
  input  logic              mbusy,
  output logic [7:0]        send_byte,
  output logic              send_imp,
  input  logic              serial_busy
);
  localparam int AW = $clog2(BUF_WORDS);
  localparam logic [7:0] BW = 8'(BUF_WORDS);
  localparam logic [8:0] BB = 9'(2 * BUF_WORDS);
  typedef enum logic [3:0] {HDR0, HDR1, HDR2, HDR3, PAYLOAD, ISSUE, WRITE, READ, SEND} state_t;
  state_t state, state_n;
  logic [15:0] mem [BUF_WORDS];
  logic [7:0] len, cnt, rptr, wptr, sidx, w_raw, words;
  logic [1:0] guard;
  logic [15:0] tx_word;
  logic rdy_q, busy_q, ev, fall, cap, tx;
  assign ev = in_data_ready & ~rdy_q;
  assign fall = busy_q & ~mbusy;
  assign w_raw = 8'((9'(in_data) + 9'd1) >> 1);
  assign words = w_raw > BW ? BW : w_raw;
  assign cap = mdata_ready && wptr < burst_len;
  assign tx = state == SEND && guard == 2'd0 && !serial_busy && sidx != {wptr[6:0], 1'b0};
  assign tx_word = mem[sidx[AW:1]];
  assign wr_data = mem[rptr[AW-1:0]];
  always_comb begin
    state_n = state;
    case (state)
      HDR0:    state_n = ev ? HDR1 : HDR0;
      HDR1:    state_n = ev ? HDR2 : HDR1;
      HDR2:    state_n = ev ? HDR3 : HDR2;
      HDR3:    state_n = !ev ? HDR3 : in_data == 8'd0 ? HDR0 : PAYLOAD;
      PAYLOAD: state_n = ev && cnt == len - 8'd1 ? ISSUE : PAYLOAD;
      ISSUE:   state_n = mbusy ? ISSUE : rdwr ? READ : WRITE;
      WRITE:   state_n = fall ? HDR0 : WRITE;
      READ:    state_n = fall || (cap && wptr + 8'd1 == burst_len) ? SEND : READ;
      SEND:    state_n = sidx == {wptr[6:0], 1'b0} ? HDR0 : SEND;
      default: state_n = HDR0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= HDR0;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b0;
      busy_q <= 1'b0;
      start <= 1'b0;
      rdwr <= 1'b0;
      addr <= '0;
      burst_len <= 8'd0;
      len <= 8'd0;
      cnt <= 8'd0;
      rptr <= 8'd0;
      wptr <= 8'd0;
      sidx <= 8'd0;
      guard <= 2'd0;
      send_byte <= 8'd0;
      send_imp <= 1'b0;
      for (int i = 0; i < BUF_WORDS; i++) mem[i] <= '0;
    end else begin
      rdy_q <= in_data_ready;
      busy_q <= mbusy;
      start <= state == ISSUE && !mbusy;
      send_imp <= tx;
      guard <= tx ? 2'd2 : guard == 2'd0 ? 2'd0 : guard - 2'd1;
      if (tx) begin
        send_byte <= sidx[0] ? tx_word[7:0] : tx_word[15:8];
        sidx <= sidx + 8'd1;
      end
      case (state)
        HDR0: if (ev) begin
          rdwr <= in_data[7];
          addr <= ADDR_W'(in_data[6:0]);
        end
        HDR1: if (ev) addr <= ADDR_W'({addr[6:0], in_data});
        HDR2: if (ev) addr <= ADDR_W'({addr[14:0], in_data});
        HDR3: if (ev) begin
          len <= in_data;
          burst_len <= words;
          cnt <= 8'd0;
          rptr <= 8'd0;
          wptr <= 8'd0;
          sidx <= 8'd0;
        end
        PAYLOAD: if (ev) begin
          cnt <= cnt + 8'd1;
          if (9'(cnt) < BB) begin
            if (cnt[0]) mem[cnt[AW:1]][7:0] <= in_data;
            else mem[cnt[AW:1]] <= {in_data, 8'h00};
          end
        end
        WRITE: if (next_wr && rptr + 8'd1 < burst_len) rptr <= rptr + 8'd1;
        READ: if (cap) begin
          mem[wptr[AW-1:0]] <= mdata;
          wptr <= wptr + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hyperram_cmd_ctrl.sv
// tb_hyperram_cmd_ctrl: randomized frames against a frame-level reference model with hbc and UART responders
module tb_hyperram_cmd_ctrl;
  logic clk = 0, rst = 1;
  logic [7:0] in_data = 0;
  logic in_data_ready = 0, next_wr = 0, mdata_ready = 0, serial_busy = 0;
  logic pre_busy = 0, hbc_busy = 0, mbusy;
  logic [15:0] mdata = 0;
  logic start, rdwr, send_imp;
  logic [23:0] addr;
  logic [7:0] burst_len, send_byte;
  logic [15:0] wr_data;
  assign mbusy = hbc_busy | pre_busy;
  always #5 clk = ~clk;
  hyperram_cmd_ctrl dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_data_ready(in_data_ready),
    .start(start), .rdwr(rdwr), .addr(addr), .burst_len(burst_len), .wr_data(wr_data),
    .next_wr(next_wr), .mdata(mdata), .mdata_ready(mdata_ready), .mbusy(mbusy),
    .send_byte(send_byte), .send_imp(send_imp), .serial_busy(serial_busy)
  );
  typedef struct packed {
    logic rd;
    logic [23:0] a;
    logic [7:0] w;
    logic [15:0][15:0] wd;
  } burst_t;
  burst_t exp_q[$];
  burst_t cur;
  logic [7:0] exp_b[$];
  logic [15:0] rd_words[$];
  int rd_n = 0, vec = 0, err = 0, k = 0, since = 100, sent = 0, nstart = 0;
  bit hbc_req = 0, hbc_act = 0, wr_act = 0, uart_slow = 1;
  logic mb_prev = 0, st_prev = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    vec++;
    if (act !== ex) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, ex);
    end
  endtask
  function automatic burst_t mk(input logic [7:0] f[$]);
    burst_t b;
    int l, w;
    logic [7:0] h0, lo;
    l = int'(f[3]);
    h0 = f[0];
    w = (l + 1) / 2;
    if (w > 16) w = 16;
    b.rd = h0[7];
    b.a = {1'b0, h0[6:0], f[1], f[2]};
    b.w = 8'(w);
    b.wd = '0;
    for (int i = 0; i < w; i++) begin
      lo = 8'h00;
      if (2 * i + 1 < l) lo = f[5 + 2 * i];
      b.wd[i] = {f[4 + 2 * i], lo};
    end
    return b;
  endfunction
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      wr_act = 0;
      since = 100;
    end else begin
      since++;
      if (start) begin
        nstart++;
        chk("start_while_busy", 32'(mbusy), 0);
        chk("start_width", 32'(st_prev), 0);
        if (!st_prev) begin
          if (exp_q.size() == 0) chk("unexpected_start", 32'(start), 0);
          else begin
            cur = exp_q.pop_front();
            chk("rdwr", 32'(rdwr), 32'(cur.rd));
            chk("addr", 32'(addr), 32'(cur.a));
            chk("burst_len", 32'(burst_len), 32'(cur.w));
            if (!cur.rd) begin
              chk("wr_data_first", 32'(wr_data), 32'(cur.wd[0]));
              wr_act = 1;
              k = 0;
            end
            hbc_req = 1;
          end
        end
      end else if (wr_act) begin
        if (next_wr) k++;
        chk("wr_data", 32'(wr_data), 32'(cur.wd[k < int'(cur.w) ? k : int'(cur.w) - 1]));
        if (mb_prev && !mbusy) wr_act = 0;
      end
      if (send_imp) begin
        chk("send_while_busy", 32'(serial_busy), 0);
        chk("send_gap", 32'(since >= 3), 1);
        since = 0;
        sent++;
        if (exp_b.size() == 0) chk("unexpected_send", 32'(send_imp), 0);
        else chk("send_byte", 32'(send_byte), 32'(exp_b.pop_front()));
      end
    end
    mb_prev = mbusy;
    st_prev = start;
  end
  initial forever begin
    burst_t b;
    int c;
    @(negedge clk);
    if (hbc_req && !rst) begin
      hbc_req = 0;
      hbc_act = 1;
      hbc_busy = 1;
      b = cur;
      if (!b.rd) begin
        for (int i = 0; i < int'(b.w) - 1 + int'($urandom_range(0, 2)); i++) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
          next_wr = 1;
          @(negedge clk);
          next_wr = 0;
        end
      end else begin
        c = rd_n < int'(b.w) ? rd_n : int'(b.w);
        for (int i = 0; i < c; i++) begin
          exp_b.push_back(rd_words[i][15:8]);
          exp_b.push_back(rd_words[i][7:0]);
        end
        for (int i = 0; i < rd_n; i++) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
          mdata = rd_words[i];
          mdata_ready = 1;
          @(negedge clk);
          mdata_ready = 0;
        end
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      hbc_busy = 0;
      hbc_act = 0;
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (send_imp && uart_slow) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      serial_busy = 1;
      repeat ($urandom_range(1, 6)) @(negedge clk);
      serial_busy = 0;
    end
  end
  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic send_frame(input logic [7:0] f[$], input int hold);
    foreach (f[i]) begin
      @(negedge clk);
      in_data = f[i];
      in_data_ready = 1;
      repeat (hold == 0 ? $urandom_range(1, 5) : hold) @(negedge clk);
      in_data_ready = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || exp_b.size() != 0 || hbc_req || hbc_act || wr_act) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 32'(t < 3000), 1);
    repeat (6) @(negedge clk);
  endtask
  task automatic frame(input logic [7:0] f[$], input int hold);
    if (f[3] != 8'd0) exp_q.push_back(mk(f));
    send_frame(f, hold);
    wait_idle();
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_start"}, 32'(start), 0);
    chk({nm, "_rdwr"}, 32'(rdwr), 0);
    chk({nm, "_addr"}, 32'(addr), 0);
    chk({nm, "_burst_len"}, 32'(burst_len), 0);
    chk({nm, "_wr_data"}, 32'(wr_data), 0);
    chk({nm, "_send_byte"}, 32'(send_byte), 0);
    chk({nm, "_send_imp"}, 32'(send_imp), 0);
  endtask
  initial begin
    logic [7:0] f1[$], f2[$], f4[$], f0[$], f[$];
    burst_t b;
    int s0, c, l, w;
    f1 = '{8'h00, 8'h00, 8'h01, 8'h08, 8'hAA, 8'h55, 8'hBB, 8'h66, 8'hCC, 8'h77, 8'hDD, 8'h88};
    f2 = '{8'h80, 8'h00, 8'h01, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    f4 = '{8'h00, 8'h12, 8'h34, 8'h03, 8'h01, 8'h02, 8'h03};
    f0 = '{8'h00, 8'h00, 8'h00, 8'h00};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    b = mk(f1);
    chk("model_w", 32'(b.w), 4);
    chk("model_w0", 32'(b.wd[0]), 32'h AA55);
    chk("model_w3", 32'(b.wd[3]), 32'h DD88);
    b = mk(f4);
    chk("model_addr", 32'(b.a), 32'h 1234);
    chk("model_w_odd", 32'(b.w), 2);
    chk("model_pad", 32'(b.wd[1]), 32'h 0300);
    frame(f1, 0);
    frame(f1, 5);
    rd_words = '{16'hAA55, 16'hBB66, 16'hCC77, 16'hDD88};
    rd_n = 4;
    s0 = sent;
    frame(f2, 0);
    chk("read_bytes_sent", 32'(sent - s0), 8);
    frame(f4, 0);
    s0 = nstart;
    frame(f0, 0);
    chk("l0_no_start", 32'(nstart - s0), 0);
    frame(f1, 0);
    pre_busy = 1;
    exp_q.push_back(mk(f1));
    s0 = nstart;
    send_frame(f1, 0);
    repeat (10) @(negedge clk);
    chk("busy_withholds_start", 32'(nstart - s0), 0);
    pre_busy = 0;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!start && c < 20);
    chk("start_after_busy_latency", 32'(c), 1);
    wait_idle();
    uart_slow = 1;
    rd_words = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    rd_n = 4;
    exp_q.push_back(mk(f2));
    s0 = sent;
    send_frame(f2, 0);
    c = 0;
    while (sent - s0 < 3 && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("reach_third_byte", 32'(c < 2000), 1);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk_zero("midsend_reset");
    @(negedge clk);
    rst = 0;
    exp_b.delete();
    exp_q.delete();
    repeat (10) @(negedge clk);
    frame(f1, 0);
    for (int n = 0; n < 40; n++) begin
      l = (n % 8 == 0) ? 0 : $urandom_range(1, 40);
      f = '{};
      f.push_back(8'($urandom_range(0, 255)));
      f.push_back(8'($urandom_range(0, 255)));
      f.push_back(8'($urandom_range(0, 255)));
      f.push_back(8'(l));
      for (int i = 0; i < l; i++) f.push_back(8'($urandom_range(0, 255)));
      w = (l + 1) / 2 > 16 ? 16 : (l + 1) / 2;
      rd_words = '{};
      for (int i = 0; i < w + 1; i++) rd_words.push_back(16'($urandom_range(0, 65535)));
      rd_n = $urandom_range(0, w + 1);
      uart_slow = $urandom_range(0, 1) == 1;
      frame(f, 0);
    end
    chk("pending_bursts", 32'(exp_q.size()), 0);
    chk("pending_bytes", 32'(exp_b.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
